// File: rtl/moving_average_mc.sv
// ============================================================================
// moving_average_mc : per-channel 2**LOG2_DEPTH-sample moving-average filter
// Rev 1.0
// ============================================================================
`default_nettype none

module moving_average_mc #(
  parameter int N          = 12,
  parameter int LOG2_DEPTH = 8,
  parameter int CHANNELS   = 4,
  parameter int ROUND      = 0,
  parameter int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [CW-1:0] in_chan,
  input  logic [N-1:0]  din,
  output logic          out_valid,
  output logic [CW-1:0] out_chan,
  output logic [N-1:0]  dout,
  output logic          out_full
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam int AW    = N + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FC_MAX = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [AW-1:0] RND = (ROUND != 0) ? AW'(DEPTH / 2) : '0;

  logic [N-1:0]          ram [CHANNELS][DEPTH];
  logic [LOG2_DEPTH-1:0] wp  [CHANNELS];
  logic [LOG2_DEPTH:0]   fc  [CHANNELS];
  logic [AW-1:0]         acc [CHANNELS];

  logic                  chan_ok;
  logic                  accept;
  logic [CW-1:0]         c;
  logic                  full_now;
  logic [N-1:0]          old;
  logic [AW-1:0]         acc_new;
  logic [N-1:0]          mean;
  logic [LOG2_DEPTH:0]   fc_next;
  logic                  full_next;

  // With a power-of-two channel count every in_chan encoding is legal.
  generate
    if (CHANNELS == (1 << CW)) begin : g_pow2
      assign chan_ok = 1'b1;
    end else begin : g_cmp
      localparam logic [CW:0] CH_LIMIT = (CW + 1)'(CHANNELS);
      assign chan_ok = ({1'b0, in_chan} < CH_LIMIT);
    end
  endgenerate

  assign accept = in_valid && chan_ok && !clear;
  // Illegal channels are steered to channel 0 only to keep array reads in range.
  assign c      = chan_ok ? in_chan : '0;

  always_comb begin
    full_now  = (fc[c] == FC_MAX);
    old       = full_now ? ram[c][wp[c]] : '0;
    acc_new   = acc[c] + AW'(din) - AW'(old);
    mean      = N'((acc_new + RND) >> LOG2_DEPTH);
    fc_next   = full_now ? fc[c] : fc[c] + 1'b1;
    full_next = (fc_next == FC_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wp[i]  <= '0;
        fc[i]  <= '0;
        acc[i] <= '0;
      end
    end else if (accept) begin
      wp[c]  <= wp[c] + 1'b1;
      fc[c]  <= fc_next;
      acc[c] <= acc_new;
    end
  end

  // Sample storage is never flushed; fc masks stale slots to zero.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      ram[c][wp[c]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_chan  <= '0;
      dout      <= '0;
      out_full  <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_chan <= c;
        dout     <= mean;
        out_full <= full_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_moving_average_mc.sv
// ============================================================================
// tb_moving_average_mc : self-checking bench over five parameter sets
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_moving_average_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  chan = 4'd0;
  logic [11:0] din = 12'd0;

  always #5 clk = ~clk;

  // Instance map: 0=warm-up/truncate, 1=rounding, 2=full scale, 3=interleave, 4=illegal/clear/reset
  logic ov_a, ov_b, ov_c, ov_d, ov_e;
  logic [0:0] oc_a, oc_b, oc_c;
  logic [1:0] oc_d, oc_e;
  logic [11:0] od_a, od_b, od_c, od_d, od_e;
  logic of_a, of_b, of_c, of_d, of_e;

  moving_average_mc #(.N(12), .LOG2_DEPTH(2), .CHANNELS(1), .ROUND(0)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_chan(chan[0:0]),
    .din(din), .out_valid(ov_a), .out_chan(oc_a), .dout(od_a), .out_full(of_a));
  moving_average_mc #(.N(12), .LOG2_DEPTH(2), .CHANNELS(1), .ROUND(1)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_chan(chan[0:0]),
    .din(din), .out_valid(ov_b), .out_chan(oc_b), .dout(od_b), .out_full(of_b));
  moving_average_mc #(.N(12), .LOG2_DEPTH(8), .CHANNELS(1), .ROUND(0)) u_c (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_chan(chan[0:0]),
    .din(din), .out_valid(ov_c), .out_chan(oc_c), .dout(od_c), .out_full(of_c));
  moving_average_mc #(.N(12), .LOG2_DEPTH(1), .CHANNELS(4), .ROUND(0)) u_d (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_chan(chan[1:0]),
    .din(din), .out_valid(ov_d), .out_chan(oc_d), .dout(od_d), .out_full(of_d));
  moving_average_mc #(.N(12), .LOG2_DEPTH(2), .CHANNELS(3), .ROUND(0)) u_e (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_chan(chan[1:0]),
    .din(din), .out_valid(ov_e), .out_chan(oc_e), .dout(od_e), .out_full(of_e));

  typedef struct {
    int sel; int ch; int d; bit v; bit clr; bit rst; bit ev; int ed; bit ef;
  } vec_t;

  typedef struct {
    int sel; bit v; int ch; int d; bit f; int tag;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tagn  = 0;
  int   cur_sel = 0;
  int   last_ch = 0;
  int   last_d  = 0;
  bit   last_f  = 1'b0;

  function automatic vec_t mk(int sel, int ch, int d, bit v, bit clr, bit rst,
                              bit ev, int ed, bit ef);
    vec_t r;
    r = '{sel: sel, ch: ch, d: d, v: v, clr: clr, rst: rst, ev: ev, ed: ed, ef: ef};
    return r;
  endfunction

  // One cycle of stimulus; the expected output state after the next edge is queued.
  task automatic cyc(input int ch, input int d, input bit v, input bit clr, input bit rst,
                     input bit ev, input int ed, input bit ef);
    exp_t e;
    @(negedge clk);
    chan     = 4'(ch);
    din      = 12'(d);
    in_valid = v;
    clear    = clr;
    reset    = rst;
    if (rst) begin
      last_ch = 0; last_d = 0; last_f = 1'b0;
    end else if (ev) begin
      last_ch = ch; last_d = ed; last_f = ef;
    end
    e = '{sel: cur_sel, v: (ev && !rst), ch: last_ch, d: last_d, f: last_f, tag: tagn};
    tagn++;
    q.push_back(e);
  endtask

  task automatic sample(input int ch, input int d, input int ed, input bit ef);
    cyc(ch, d, 1'b1, 1'b0, 1'b0, 1'b1, ed, ef);
  endtask

  task automatic do_reset(input int sel);
    cur_sel = sel;
    cyc(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      bit av; int ach; int ad; bit af;
      m = q.pop_front();
      case (m.sel)
        0: begin av = ov_a; ach = int'(oc_a); ad = int'(od_a); af = of_a; end
        1: begin av = ov_b; ach = int'(oc_b); ad = int'(od_b); af = of_b; end
        2: begin av = ov_c; ach = int'(oc_c); ad = int'(od_c); af = of_c; end
        3: begin av = ov_d; ach = int'(oc_d); ad = int'(od_d); af = of_d; end
        default: begin av = ov_e; ach = int'(oc_e); ad = int'(od_e); af = of_e; end
      endcase
      n_cmp++;
      if (av !== m.v || ach != m.ch || ad != m.d || af !== m.f) begin
        n_bad++;
        $display("FAIL out tag=%0d dut=%0d: got v=%0d ch=%0d dout=%0d full=%0d, want v=%0d ch=%0d dout=%0d full=%0d",
                 m.tag, m.sel, av, ach, ad, af, m.v, m.ch, m.d, m.f);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[$];
    // Warm-up and truncation (dut 0)
    tv.push_back(mk(0, 0, 0,   0, 0, 1, 0, 0,   0));
    tv.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0,   0));
    tv.push_back(mk(0, 0, 100, 1, 0, 0, 1, 25,  0));
    tv.push_back(mk(0, 0, 200, 1, 0, 0, 1, 75,  0));
    tv.push_back(mk(0, 0, 300, 1, 0, 0, 1, 150, 0));
    tv.push_back(mk(0, 0, 400, 1, 0, 0, 1, 250, 1));
    tv.push_back(mk(0, 0, 500, 1, 0, 0, 1, 350, 1));
    tv.push_back(mk(0, 0, 0,   0, 0, 0, 0, 0,   0));
    tv.push_back(mk(0, 0, 0,   0, 0, 1, 0, 0,   0));
    tv.push_back(mk(0, 0, 2,   1, 0, 0, 1, 0,   0));
    // Rounding (dut 1)
    tv.push_back(mk(1, 0, 0,    0, 0, 1, 0, 0,    0));
    tv.push_back(mk(1, 0, 2,    1, 0, 0, 1, 1,    0));
    tv.push_back(mk(1, 0, 0,    0, 0, 1, 0, 0,    0));
    tv.push_back(mk(1, 0, 4095, 1, 0, 0, 1, 1024, 0));
    // Interleaved channels, depth 2 (dut 3)
    tv.push_back(mk(3, 0, 0,    0, 0, 1, 0, 0,    0));
    tv.push_back(mk(3, 0, 10,   1, 0, 0, 1, 5,    0));
    tv.push_back(mk(3, 1, 1000, 1, 0, 0, 1, 500,  0));
    tv.push_back(mk(3, 0, 20,   1, 0, 0, 1, 15,   1));
    tv.push_back(mk(3, 0, 30,   1, 0, 0, 1, 25,   1));
    tv.push_back(mk(3, 3, 4000, 1, 0, 0, 1, 2000, 0));
    tv.push_back(mk(3, 1, 3000, 1, 0, 0, 1, 2000, 1));
    tv.push_back(mk(3, 2, 7,    1, 0, 0, 1, 3,    0));

    for (int i = 0; i < tv.size(); i++) begin
      cur_sel = tv[i].sel;
      cyc(tv[i].ch, tv[i].d, tv[i].v, tv[i].clr, tv[i].rst, tv[i].ev, tv[i].ed, tv[i].ef);
    end

    // Full scale then drain to zero, depth 256 (dut 2)
    do_reset(2);
    for (int i = 1; i <= 300; i++)
      sample(0, 4095, (i >= 256) ? 4095 : ((i * 4095) >> 8), (i >= 256));
    for (int j = 1; j <= 256; j++)
      sample(0, 0, ((256 - j) * 4095) >> 8, 1'b1);

    // Illegal channel, clear and reset collisions (dut 4, 3 channels, depth 4)
    do_reset(4);
    sample(0, 40, 10, 1'b0);
    sample(1, 80, 20, 1'b0);
    cyc(3, 999, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    sample(0, 40, 20, 1'b0);
    sample(0, 40, 30, 1'b0);
    sample(0, 40, 40, 1'b1);
    sample(0, 4, 31, 1'b1);
    cyc(0, 800, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    sample(0, 800, 200, 1'b0);
    sample(1, 8, 2, 1'b0);
    sample(0, 100, 225, 1'b0);
    cyc(0, 800, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    sample(0, 800, 200, 1'b0);
    cyc(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
